// File: rtl/operand_sequencer.sv
// Operand entry sequencer: debounces the "enter" key, latches x / y / op on
// successive presses and captures the arithmetic stage's result once per set.
module operand_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic       CLOCK_50,
  input  logic       KEY0,
  input  logic       KEY1,
  input  logic [3:0] SW,
  input  logic       SW9,
  input  logic       SW8,
  output logic [3:0] x,
  output logic [3:0] y,
  output logic [1:0] op,
  output logic       valid,
  input  logic [9:0] arithrslt,
  output logic [9:0] result,
  output logic       done,
  output logic [1:0] state
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_X = 2'b00,
    WAIT_Y = 2'b01,
    READY  = 2'b10
  } state_t;

  logic             sync1;
  logic             sync2;
  logic             deb;
  logic             deb_q;
  logic [CNT_W-1:0] cnt;
  logic             press;
  logic [1:0]       state_q;

  // Key conditioning: 2-flop synchronizer, stability debounce, falling-edge pulse.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      deb   <= 1'b1;
      deb_q <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= KEY1;
      sync2 <= sync1;
      deb_q <= deb;
      press <= deb_q & ~deb;
      if (sync2 != deb) begin
        if (cnt == CNT_LAST) begin
          deb <= sync2;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // Operand FSM and result capture; a press in READY pre-empts a pending capture.
  always_ff @(posedge CLOCK_50) begin
    if (!KEY0) begin
      state_q <= WAIT_X;
      x       <= '0;
      y       <= '0;
      op      <= '0;
      valid   <= 1'b0;
      result  <= '0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        WAIT_X: begin
          if (press) begin
            x       <= SW;
            state_q <= WAIT_Y;
          end
        end
        WAIT_Y: begin
          if (press) begin
            y       <= SW;
            op      <= {SW9, SW8};
            valid   <= 1'b1;
            state_q <= READY;
          end
        end
        READY: begin
          if (press) begin
            x       <= SW;
            valid   <= 1'b0;
            done    <= 1'b0;
            state_q <= WAIT_Y;
          end
        end
        default: state_q <= WAIT_X;
      endcase

      if (valid && !done && !(press && state_q == READY)) begin
        result <= arithrslt;
        done   <= 1'b1;
      end
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed scenarios plus random key/switch traffic,
// every cycle compared against a sample-history reference model.
module tb_operand_sequencer;
  localparam int unsigned DEB = 4;

  logic       CLOCK_50 = 1'b0;
  logic       KEY0;
  logic       KEY1;
  logic [3:0] SW;
  logic       SW9;
  logic       SW8;
  logic [9:0] arithrslt;
  logic [3:0] x;
  logic [3:0] y;
  logic [1:0] op;
  logic       valid;
  logic [9:0] result;
  logic       done;
  logic [1:0] state;

  operand_sequencer #(.DEBOUNCE_CYCLES(DEB)) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .KEY1     (KEY1),
    .SW       (SW),
    .SW9      (SW9),
    .SW8      (SW8),
    .x        (x),
    .y        (y),
    .op       (op),
    .valid    (valid),
    .arithrslt(arithrslt),
    .result   (result),
    .done     (done),
    .state    (state)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  bit         key_hist[$];
  bit         ks_hist[$];
  bit         m_deb;
  bit         m_fell;
  bit         m_press;
  int         m_state;
  logic [3:0] m_x;
  logic [3:0] m_y;
  logic [1:0] m_op;
  bit         m_valid;
  bit         m_done;
  logic [9:0] m_result;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at that edge.
  task automatic model_edge();
    bit p;
    bit cap;
    bit ks;
    bit all_diff;
    if (!KEY0) begin
      key_hist.delete();
      ks_hist.delete();
      m_deb = 1'b1; m_fell = 1'b0; m_press = 1'b0;
      m_state = 0; m_x = '0; m_y = '0; m_op = '0;
      m_valid = 1'b0; m_done = 1'b0; m_result = '0;
      return;
    end
    p   = m_press;
    cap = m_valid && !m_done && !(p && m_state == 2);
    case (m_state)
      0: if (p) begin m_x = SW; m_state = 1; end
      1: if (p) begin m_y = SW; m_op = {SW9, SW8}; m_valid = 1'b1; m_state = 2; end
      2: if (p) begin m_x = SW; m_valid = 1'b0; m_done = 1'b0; m_state = 1; end
      default: m_state = 0;
    endcase
    if (cap) begin
      m_result = arithrslt;
      m_done   = 1'b1;
    end
    // key_s seen at this edge is the KEY1 sample from two edges ago
    ks = (key_hist.size() >= 2) ? key_hist[key_hist.size()-2] : 1'b1;
    key_hist.push_back(KEY1);
    while (key_hist.size() > 2) void'(key_hist.pop_front());
    ks_hist.push_back(ks);
    while (ks_hist.size() > DEB) void'(ks_hist.pop_front());
    m_press = m_fell;
    m_fell  = 1'b0;
    if (ks_hist.size() == DEB) begin
      all_diff = 1'b1;
      foreach (ks_hist[i]) if (ks_hist[i] == m_deb) all_diff = 1'b0;
      if (all_diff) begin
        m_fell = m_deb;
        m_deb  = ~m_deb;
      end
    end
  endtask

  task automatic check_all();
    check("state",  32'(state),     32'(m_state));
    check("x",      32'(x),         32'(m_x));
    check("y",      32'(y),         32'(m_y));
    check("op",     32'(op),        32'(m_op));
    check("valid",  32'(valid),     32'(m_valid));
    check("done",   32'(done),      32'(m_done));
    check("result", 32'(result),    32'(m_result));
    check("press",  32'(dut.press), 32'(m_press));
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    KEY0 = 1'b0;
    step();
    KEY0 = 1'b1;
  endtask

  // Hold the key low long enough for one press, then release until settled.
  task automatic press_key();
    KEY1 = 1'b0;
    repeat (DEB + 6) step();
    KEY1 = 1'b1;
    repeat (DEB + 4) step();
  endtask

  int press_at;
  int n_press;

  initial begin
    KEY0 = 1'b0; KEY1 = 1'b1; SW = '0; SW9 = 1'b0; SW8 = 1'b0; arithrslt = '0;
    step();
    step();
    KEY0 = 1'b1;

    // Short glitch must not register
    KEY1 = 1'b0;
    repeat (3) step();
    KEY1 = 1'b1;
    n_press = 0;
    repeat (10) begin
      step();
      if (dut.press) n_press++;
    end
    check("glitch_press", 32'(n_press), 32'd0);
    check("glitch_state", 32'(state), 32'd0);

    // Long hold: single press, exact latency
    SW = 4'hA; KEY1 = 1'b0; press_at = -1; n_press = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (dut.press) begin
        n_press++;
        if (press_at < 0) press_at = k;
      end
    end
    check("press_lat", 32'(press_at), 32'(DEB + 2));
    check("press_cnt", 32'(n_press), 32'd1);
    check("hold_state", 32'(state), 32'd1);
    check("hold_x", 32'(x), 32'hA);
    KEY1 = 1'b1;
    repeat (DEB + 4) step();

    // Full operand set and capture
    do_reset();
    arithrslt = 10'h006;
    SW = 4'h9; press_key();
    SW = 4'h3; SW9 = 1'b0; SW8 = 1'b1; press_key();
    check("set_x", 32'(x), 32'h9);
    check("set_y", 32'(y), 32'h3);
    check("set_op", 32'(op), 32'h1);
    check("set_valid", 32'(valid), 32'd1);
    check("set_done", 32'(done), 32'd1);
    check("set_result", 32'(result), 32'h006);

    // New pair from READY keeps old result
    arithrslt = 10'h3FF;
    SW = 4'hF; press_key();
    check("rdy_state", 32'(state), 32'd1);
    check("rdy_x", 32'(x), 32'hF);
    check("rdy_valid", 32'(valid), 32'd0);
    check("rdy_done", 32'(done), 32'd0);
    check("rdy_result", 32'(result), 32'h006);

    // Reset mid-debounce, key kept low across release
    KEY1 = 1'b0;
    repeat (3) step();
    KEY0 = 1'b0;
    step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_x", 32'(x), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    KEY0 = 1'b1; press_at = -1;
    for (int k = 0; k < 15; k++) begin
      step();
      if (dut.press && press_at < 0) press_at = k;
    end
    check("rst_press_lat", 32'(press_at), 32'(DEB + 2));
    KEY1 = 1'b1;
    repeat (DEB + 4) step();

    // Random traffic
    for (int burst = 0; burst < 40; burst++) begin
      int lo_len;
      int hi_len;
      lo_len = $urandom_range(1, 10);
      hi_len = $urandom_range(1, 10);
      for (int c = 0; c < lo_len + hi_len; c++) begin
        KEY1 = (c >= lo_len);
        SW = 4'($urandom);
        SW9 = 1'($urandom);
        SW8 = 1'($urandom);
        arithrslt = 10'($urandom);
        KEY0 = ($urandom_range(0, 59) != 0);
        step();
      end
    end
    KEY0 = 1'b1; KEY1 = 1'b1;
    repeat (DEB + 4) step();

    // Illegal state recovery
    do_reset();
    SW9 = 1'b1; SW8 = 1'b0;
    SW = 4'h5; press_key();
    SW = 4'h6; press_key();
    check("pre_ill_state", 32'(state), 32'd2);
    force dut.state_q = 2'b11;
    #1;
    release dut.state_q;
    m_state = 3;
    step();
    check("ill_state", 32'(state), 32'd0);
    check("ill_x", 32'(x), 32'h5);
    check("ill_y", 32'(y), 32'h6);
    check("ill_op", 32'(op), 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive stable synchronized samples required to accept a KEY1 level change; legal range 2..2^20.
REQ-002 The block SHALL have port CLOCK_50  input  1  sole clock; all flops update on its rising edge.
REQ-003 The block SHALL have port KEY0  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port KEY1  input  1  raw "enter" pushbutton, active-low (pressed = 0), asynchronous to CLOCK_50.
REQ-005 The block SHALL have port SW  input  4  operand data switches.
REQ-006 The block SHALL have ports SW9, SW8  input  1 each  operation select (00 add, 01 subtract, 10 multiply-by-2, 11 divide-by-2).
REQ-007 The block SHALL have ports x, y  output  4 each  latched operands to the arithmetic stage.
REQ-008 The block SHALL have port op  output  2  latched operation, op[1] = SW9, op[0] = SW8.
REQ-009 The block SHALL have port valid  output  1  high while x, y and op form a complete operand set.
REQ-010 The block SHALL have port arithrslt  input  10  combinational result returned by the arithmetic stage for the current x, y and op.
REQ-011 The block SHALL have port result  output  10  captured arithmetic result.
REQ-012 The block SHALL have port done  output  1  high while result holds the result for the current operand set.
REQ-013 The block SHALL have port state  output  2  current FSM state encoding, for LED display.

Function
- Input conditioning
  - REQ-014 KEY1 SHALL pass through a two-flop synchronizer; the output is key_s.
  - REQ-015 A debounced level deb SHALL change to key_s on the DEBOUNCE_CYCLES-th consecutive edge at which key_s != deb; the stability counter SHALL clear on any edge at which key_s == deb.
  - REQ-016 A registered pulse press SHALL be high for exactly one cycle after the edge following a 1->0 transition of deb; a 0->1 transition SHALL NOT produce press.
  - REQ-017 Latency: with KEY1 held low from edge E0 (first edge sampling 0), press SHALL be high in the cycle after edge E0+DEBOUNCE_CYCLES+2.
  - REQ-018 A KEY1 low glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL NOT produce press.
  - REQ-019 Holding KEY1 low indefinitely SHALL produce exactly one press.
- FSM: WAIT_X = 2'b00, WAIT_Y = 2'b01, READY = 2'b10; 2'b11 is illegal and SHALL go to WAIT_X on the next edge.
  - REQ-020 In WAIT_X, on press: x <= SW; next state WAIT_Y.
  - REQ-021 In WAIT_Y, on press: y <= SW; op <= {SW9, SW8}; valid <= 1; next state READY.
  - REQ-022 In READY, on press: x <= SW; valid <= 0; done <= 0; next state WAIT_Y (a new operand pair begins).
  - REQ-023 Without press, state, x, y and op SHALL hold; SW, SW9 and SW8 changes SHALL have no effect.
- Result capture
  - REQ-024 At the first edge at which valid = 1 and done = 0, result <= arithrslt and done <= 1, so done rises exactly one cycle after valid.
  - REQ-025 While done = 1, result SHALL hold regardless of arithrslt.
  - REQ-026 result SHALL be captured as all 10 bits with no truncation or sign handling.
  - REQ-027 When valid falls, done SHALL clear on the same edge and result SHALL retain its old value.
  - REQ-028 A press coinciding with the capture edge (READY, done = 0) SHALL take priority: the REQ-022 state change applies and no capture occurs.

Reset
- REQ-029 When KEY0 = 0 at a rising edge, the following SHALL take effect on that edge:
  - state = WAIT_X; x = 0; y = 0; op = 0; valid = 0; result = 0; done = 0;
  - synchronizer flops = 1; deb = 1; stability counter = 0; press = 0.
- REQ-030 Reset SHALL override press in any state, including mid-debounce and mid-capture.
- REQ-031 A key held through reset release SHALL require a fresh DEBOUNCE_CYCLES-stable low sequence before press.
- REQ-032 Outputs SHALL be undefined only before the first reset edge.

Verification (DEBOUNCE_CYCLES = 4)
- REQ-033 KEY1 low from E0, held 20 cycles -> press high only in the cycle after E0+6; state 00 -> 01; x = SW.
- REQ-034 KEY1 low for 3 cycles, then high -> no press; state stays 00.
- REQ-035 Sequence: SW = 4'h9, press; SW = 4'h3, SW9/SW8 = 01, press; arithrslt driven 10'h006 -> valid high; done high one cycle later with result = 10'h006; x = 9, y = 3, op = 01.
- REQ-036 In READY with done = 1: SW = 4'hF, press -> state 01, x = F, valid = 0, done = 0, result still 10'h006.
- REQ-037 KEY0 = 0 for one edge during WAIT_Y with KEY1 mid-debounce -> all outputs 0 at that edge; KEY1 kept low afterwards -> press occurs DEBOUNCE_CYCLES+2 edges after reset release, not earlier.
- REQ-038 Force state to 2'b11 -> state = 2'b00 after one edge; x, y and op unchanged.
